regfile_2w4r_sb: RTL and testbench
==================================

Name: regfile_2w4r_sb

Overview:
- Dual-issue architectural register file for the 2-wide pipeline: 32 x 32-bit registers, 2 write ports (writeback), 4 read ports (decode/issue).
- Reads are registered with same-cycle write-to-read bypass.
- Carries a per-register pending scoreboard.
  - Set when issue allocates a destination.
  - Cleared when writeback commits that destination.
  - Each read port reports a registered ready flag, so issue can stall on RAW hazards.
- Sits between the decode/issue stage (reader/allocator) and the writeback stage (writer).

Parameters:
- WIDTH, 32, data width of each register.
- NREG, 32, number of registers; must be a power of two.
- AW, 5, register-index width; AW = log2(NREG).

Ports:
- clock  in  1  rising-edge clock for all state.
- ctrl_reset  in  1  synchronous, active-high reset.
- ctrl_writeEnable_a  in  1  writeback port A valid (older instruction).
- ctrl_writeReg_a  in  AW  destination index, port A.
- data_writeReg_a  in  WIDTH  write data, port A.
- ctrl_writeEnable_b  in  1  writeback port B valid (younger instruction).
- ctrl_writeReg_b  in  AW  destination index, port B.
- data_writeReg_b  in  WIDTH  write data, port B.
- ctrl_alloc_a  in  1  issue slot A allocates a destination (mark pending).
- ctrl_allocReg_a  in  AW  destination index allocated by slot A.
- ctrl_alloc_b  in  1  issue slot B allocates a destination (younger than slot A).
- ctrl_allocReg_b  in  AW  destination index allocated by slot B.
- ctrl_readReg_0..3  in  AW each  four read-port source indices.
- data_readReg_0..3  out  WIDTH each  registered read data.
- ready_0..3  out  1 each  registered: source register not pending.

Behaviour:
- Reset (ctrl_reset=1 at a rising edge) takes priority over every other input in that cycle:
  - all NREG registers := 0.
  - all pending bits := 0.
  - data_readReg_0..3 := 0.
  - ready_0..3 := 1.
- Register 0:
  - always reads 0 and is always ready.
  - writes and allocs to index 0 are ignored.
- Write, each edge with reset=0:
  - port A writes if ctrl_writeEnable_a=1 and index != 0; port B likewise.
  - If both write the same index, port B's data wins.
- Read latency is 1 cycle. data_readReg_k after edge t = register[ctrl_readReg_k] as it will be after edge t's writes (write-first bypass).
  - A write at edge t is therefore visible on the read outputs immediately after edge t; there is no extra-cycle stale window.
  - Bypass priority: port B over port A over array contents.
- Scoreboard: one pending bit per register. Next-state of pending[i], in priority order (highest first):
  1. reset -> 0.
  2. alloc by A or B to i -> 1.
  3. writeback by A or B to i -> 0.
  4. otherwise hold.
- Alloc beats writeback to the same index in the same cycle: the newer producer stays outstanding.
- Two allocs to the same index in one cycle -> pending=1 (idempotent).
- A writeback to a non-pending register is legal: it updates data and pending stays 0.
- ready_k after edge t = NOT pending[ctrl_readReg_k] as it will be after edge t. It is forced to 1 when ctrl_readReg_k = 0.
- All four read ports are independent and may name the same index. Outputs are identical in that case.
- No combinational path from any input to any output; all outputs are flops.
- Reset asserted mid-stream discards in-flight writes and allocs of that cycle. The first post-reset cycle behaves as from power-up.

Test Plan:
- Reset for 2 cycles, then read indices 0,1,17,31 -> all data_readReg_k = 0, all ready_k = 1.
- Same cycle: write A r5=0x0000_1234, read_0=5 -> after that edge data_readReg_0 = 0x0000_1234 (bypass). Then hold read_0=5 with no write -> value persists.
- Dual write conflict: A r7=0xAAAA_AAAA, B r7=0x5555_5555, read_1=7 -> data_readReg_1 = 0x5555_5555. Next cycle still 0x5555_5555.
- Scoreboard lifecycle:
  - alloc_a r9 -> next edge ready(read 9) = 0.
  - two idle cycles -> ready stays 0.
  - write B r9=0xDEAD_BEEF -> same edge ready = 1 and data = 0xDEAD_BEEF.
- Alloc/writeback collision: r12 pending; alloc_b r12 and write A r12=0x1 in the same cycle -> data reads 0x1, ready(r12) stays 0.
- r0 and mid-stream reset:
  - write r0=0xFFFF_FFFF plus alloc r0 -> reads 0, ready 1.
  - then with r3=0x42 stored and r4 pending, assert reset together with write r3=0x99 -> after edge r3 reads 0 and ready(r4) = 1.

Source files
------------

// File: rtl/regfile_2w4r_sb.sv
// 2-write / 4-read register file with write-first bypass and a
// per-register pending scoreboard for RAW stall detection.
module regfile_2w4r_sb #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32,
    parameter int AW    = 5
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_writeEnable_a,
    input  logic [AW-1:0]    ctrl_writeReg_a,
    input  logic [WIDTH-1:0] data_writeReg_a,
    input  logic             ctrl_writeEnable_b,
    input  logic [AW-1:0]    ctrl_writeReg_b,
    input  logic [WIDTH-1:0] data_writeReg_b,
    input  logic             ctrl_alloc_a,
    input  logic [AW-1:0]    ctrl_allocReg_a,
    input  logic             ctrl_alloc_b,
    input  logic [AW-1:0]    ctrl_allocReg_b,
    input  logic [AW-1:0]    ctrl_readReg_0,
    input  logic [AW-1:0]    ctrl_readReg_1,
    input  logic [AW-1:0]    ctrl_readReg_2,
    input  logic [AW-1:0]    ctrl_readReg_3,
    output logic [WIDTH-1:0] data_readReg_0,
    output logic [WIDTH-1:0] data_readReg_1,
    output logic [WIDTH-1:0] data_readReg_2,
    output logic [WIDTH-1:0] data_readReg_3,
    output logic             ready_0,
    output logic             ready_1,
    output logic             ready_2,
    output logic             ready_3
);

    logic [WIDTH-1:0] regs     [NREG];
    logic [WIDTH-1:0] regs_nxt [NREG];
    logic [NREG-1:0]  pending;
    logic [NREG-1:0]  pend_nxt;
    logic [NREG-1:0]  wen_a;
    logic [NREG-1:0]  wen_b;
    logic [NREG-1:0]  alc;

    logic [AW-1:0]    rd_idx   [4];
    logic [WIDTH-1:0] rd_data  [4];
    logic             rd_ready [4];

    assign rd_idx[0] = ctrl_readReg_0;
    assign rd_idx[1] = ctrl_readReg_1;
    assign rd_idx[2] = ctrl_readReg_2;
    assign rd_idx[3] = ctrl_readReg_3;

    // Index 0 never decodes, so r0 stays zero and never goes pending.
    always_comb begin
        wen_a = '0;
        wen_b = '0;
        alc   = '0;
        for (int i = 1; i < NREG; i++) begin
            wen_a[i] = ctrl_writeEnable_a && (ctrl_writeReg_a == AW'(i));
            wen_b[i] = ctrl_writeEnable_b && (ctrl_writeReg_b == AW'(i));
            alc[i]   = (ctrl_alloc_a && (ctrl_allocReg_a == AW'(i))) ||
                       (ctrl_alloc_b && (ctrl_allocReg_b == AW'(i)));
        end
    end

    // Alloc beats writeback so a newer producer stays outstanding.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_nxt[i] = wen_b[i] ? data_writeReg_b :
                          wen_a[i] ? data_writeReg_a : regs[i];
            pend_nxt[i] = alc[i] | (pending[i] & ~(wen_a[i] | wen_b[i]));
        end
        regs_nxt[0] = '0;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            pending <= '0;
            for (int k = 0; k < 4; k++) begin
                rd_data[k]  <= '0;
                rd_ready[k] <= 1'b1;
            end
        end else begin
            for (int i = 0; i < NREG; i++) regs[i] <= regs_nxt[i];
            pending <= pend_nxt;
            for (int k = 0; k < 4; k++) begin
                rd_data[k]  <= regs_nxt[rd_idx[k]];
                rd_ready[k] <= ~pend_nxt[rd_idx[k]];
            end
        end
    end

    assign data_readReg_0 = rd_data[0];
    assign data_readReg_1 = rd_data[1];
    assign data_readReg_2 = rd_data[2];
    assign data_readReg_3 = rd_data[3];
    assign ready_0        = rd_ready[0];
    assign ready_1        = rd_ready[1];
    assign ready_2        = rd_ready[2];
    assign ready_3        = rd_ready[3];

endmodule

// File: tb/tb_regfile_2w4r_sb.sv
// Bench for regfile_2w4r_sb: reference model feeds a scoreboard queue,
// plus directed checks of bypass, port priority and pending lifecycle.
module tb_regfile_2w4r_sb;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        we_a, we_b, al_a, al_b;
    logic [4:0]  wa, wb, aa, ab;
    logic [31:0] da, db;
    logic [4:0]  rd [4];
    logic [31:0] d0, d1, d2, d3;
    logic        r0, r1, r2, r3;

    typedef struct packed {
        logic [3:0][31:0] d;
        logic [3:0]       r;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] m_reg  [32];
    logic        m_pend [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clock = ~clock;

    regfile_2w4r_sb dut (
        .clock              (clock),
        .ctrl_reset         (ctrl_reset),
        .ctrl_writeEnable_a (we_a),
        .ctrl_writeReg_a    (wa),
        .data_writeReg_a    (da),
        .ctrl_writeEnable_b (we_b),
        .ctrl_writeReg_b    (wb),
        .data_writeReg_b    (db),
        .ctrl_alloc_a       (al_a),
        .ctrl_allocReg_a    (aa),
        .ctrl_alloc_b       (al_b),
        .ctrl_allocReg_b    (ab),
        .ctrl_readReg_0     (rd[0]),
        .ctrl_readReg_1     (rd[1]),
        .ctrl_readReg_2     (rd[2]),
        .ctrl_readReg_3     (rd[3]),
        .data_readReg_0     (d0),
        .data_readReg_1     (d1),
        .data_readReg_2     (d2),
        .data_readReg_3     (d3),
        .ready_0            (r0),
        .ready_1            (r1),
        .ready_2            (r2),
        .ready_3            (r3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        we_a = 0; we_b = 0; al_a = 0; al_b = 0;
        wa = 0; wb = 0; aa = 0; ab = 0; da = 0; db = 0;
    endtask

    // Model applies writes A then B, clears on writeback, then sets on alloc.
    task automatic cycle();
        exp_t e;
        exp_t g;
        if (ctrl_reset) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = 0; m_pend[i] = 0;
            end
        end else begin
            if (we_a && wa != 0) begin m_reg[wa] = da; m_pend[wa] = 0; end
            if (we_b && wb != 0) begin m_reg[wb] = db; m_pend[wb] = 0; end
            if (al_a && aa != 0) m_pend[aa] = 1;
            if (al_b && ab != 0) m_pend[ab] = 1;
        end
        for (int k = 0; k < 4; k++) begin
            e.d[k] = ctrl_reset ? 32'h0 : m_reg[rd[k]];
            e.r[k] = ctrl_reset || rd[k] == 0 || !m_pend[rd[k]];
        end
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        g.d = {d3, d2, d1, d0};
        g.r = {r3, r2, r1, r0};
        if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("sb_d%0d", k), g.d[k], e.d[k]);
                chk($sformatf("sb_r%0d", k), 32'(g.r[k]), 32'(e.r[k]));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_pend[i] = 0; end
        idle();
        for (int k = 0; k < 4; k++) rd[k] = 0;
        ctrl_reset = 1;
        @(posedge clock); #1;
        cycle();
        cycle();
        ctrl_reset = 0;

        rd[0] = 0; rd[1] = 1; rd[2] = 17; rd[3] = 31;
        cycle();
        chk("rst_d0", d0, 0); chk("rst_d3", d3, 0);
        chk("rst_rdy", {r0, r1, r2, r3}, 4'hF);

        we_a = 1; wa = 5; da = 32'h0000_1234; rd[0] = 5;
        cycle();
        chk("bypass", d0, 32'h0000_1234);
        idle();
        cycle();
        chk("persist", d0, 32'h0000_1234);

        we_a = 1; wa = 7; da = 32'hAAAA_AAAA;
        we_b = 1; wb = 7; db = 32'h5555_5555; rd[1] = 7;
        cycle();
        chk("b_wins", d1, 32'h5555_5555);
        idle();
        cycle();
        chk("b_wins_hold", d1, 32'h5555_5555);

        al_a = 1; aa = 9; rd[2] = 9;
        cycle();
        chk("pend_set", r2, 0);
        idle();
        cycle();
        cycle();
        chk("pend_hold", r2, 0);
        we_b = 1; wb = 9; db = 32'hDEAD_BEEF;
        cycle();
        chk("wb_rdy", r2, 1);
        chk("wb_data", d2, 32'hDEAD_BEEF);
        idle();

        al_a = 1; aa = 12; rd[3] = 12;
        cycle();
        idle();
        al_b = 1; ab = 12; we_a = 1; wa = 12; da = 32'h1;
        cycle();
        chk("coll_data", d3, 32'h1);
        chk("coll_rdy", r3, 0);
        idle();

        we_a = 1; wa = 0; da = 32'hFFFF_FFFF; al_a = 1; aa = 0; rd[0] = 0;
        cycle();
        chk("r0_data", d0, 0);
        chk("r0_rdy", r0, 1);
        idle();

        we_a = 1; wa = 3; da = 32'h42; al_b = 1; ab = 4;
        rd[0] = 3; rd[1] = 4;
        cycle();
        chk("pre_r3", d0, 32'h42);
        chk("pre_r4", r1, 0);
        idle();
        ctrl_reset = 1; we_a = 1; wa = 3; da = 32'h99;
        cycle();
        chk("mrst_d", d0, 0);
        chk("mrst_rdy", r1, 1);
        ctrl_reset = 0;
        idle();
        cycle();
        chk("post_rst", d0, 0);

        for (int n = 0; n < 300; n++) begin
            we_a = 1'($urandom); wa = 5'($urandom_range(0, 7));
            we_b = 1'($urandom); wb = 5'($urandom_range(0, 7));
            da = $urandom; db = $urandom;
            al_a = 1'($urandom); aa = 5'($urandom_range(0, 7));
            al_b = 1'($urandom); ab = 5'($urandom_range(0, 7));
            for (int k = 0; k < 4; k++) rd[k] = 5'($urandom_range(0, 8));
            ctrl_reset = ($urandom_range(0, 60) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
